// File: rtl/multiword_subtract_sequencer_pkg.sv
// Shared constants and state encoding for the
// multi-word subtract sequencer.
package multiword_subtract_sequencer_pkg;

  localparam int WIDTH = 32;
  localparam int NST   = 5;

  localparam int IDLE   = 0;
  localparam int ACCEPT = 1;
  localparam int EVAL   = 2;
  localparam int EMIT   = 3;
  localparam int FINISH = 4;

  typedef logic [NST-1:0] state_t;

  localparam state_t ST_IDLE   = 5'b00001;
  localparam state_t ST_ACCEPT = 5'b00010;
  localparam state_t ST_EVAL   = 5'b00100;
  localparam state_t ST_EMIT   = 5'b01000;
  localparam state_t ST_FINISH = 5'b10000;

  function automatic int cw_of(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/multiword_subtract_sequencer_if.sv
// Operand stream, subtractor hookup, result stream
// and status of the multi-word subtract sequencer.
interface multiword_subtract_sequencer_if;
  import multiword_subtract_sequencer_pkg::*;

  logic             start;
  logic             borrow_in;
  logic             word_valid;
  logic             word_ready;
  logic [WIDTH-1:0] a_word;
  logic [WIDTH-1:0] b_word;
  logic [WIDTH-1:0] sub_x;
  logic [WIDTH-1:0] sub_y;
  logic             sub_b0;
  logic [WIDTH-1:0] sub_d;
  logic             sub_b32;
  logic [WIDTH-1:0] res_word;
  logic             res_valid;
  logic             res_ready;
  logic             res_last;
  logic             done;
  logic             borrow_out;
  logic             zero;
  logic             busy;

  modport slave (
    input  start, borrow_in, word_valid,
    input  a_word, b_word,
    input  sub_d, sub_b32, res_ready,
    output word_ready, sub_x, sub_y, sub_b0,
    output res_word, res_valid, res_last,
    output done, borrow_out, zero, busy
  );

  modport master (
    output start, borrow_in, word_valid,
    output a_word, b_word,
    output sub_d, sub_b32, res_ready,
    input  word_ready, sub_x, sub_y, sub_b0,
    input  res_word, res_valid, res_last,
    input  done, borrow_out, zero, busy
  );

endinterface

// File: rtl/multiword_subtract_sequencer.sv
// Sequences an N-word A - B - borrow_in through an
// external 32-bit ripple subtractor, LS word first.
module multiword_subtract_sequencer
  import multiword_subtract_sequencer_pkg::*;
#(
  parameter int WORDS = 4
) (
  input logic clk,
  input logic rst_n,
  multiword_subtract_sequencer_if.slave bus
);

  localparam int CW = cw_of(WORDS);
  localparam logic [CW-1:0] LAST = CW'(WORDS - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] opx_q, opx_d;
  logic [WIDTH-1:0] opy_q, opy_d;
  logic             borrow_q, borrow_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             zacc_q, zacc_d;
  logic [WIDTH-1:0] res_word_q, res_word_d;
  logic             res_last_q, res_last_d;
  logic             bout_q, bout_d;
  logic             zero_q, zero_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (1'b1)
      state_q[IDLE]:
        if (bus.start) state_d = ST_ACCEPT;
      state_q[ACCEPT]:
        if (bus.word_valid) state_d = ST_EVAL;
      state_q[EVAL]:
        state_d = ST_EMIT;
      state_q[EMIT]:
        if (bus.res_ready)
          state_d = res_last_q ? ST_FINISH
                               : ST_ACCEPT;
      state_q[FINISH]:
        state_d = ST_IDLE;
      default:
        state_d = ST_IDLE;
    endcase
  end

  // Subtractor inputs come only from registers so the
  // ripple chain sees stable operands for all of EVAL.
  always_comb begin
    bus.word_ready = state_q[ACCEPT];
    bus.res_valid  = state_q[EMIT];
    bus.done       = state_q[FINISH];
    bus.busy       = ~state_q[IDLE];
    bus.sub_x      = opx_q;
    bus.sub_y      = opy_q;
    bus.sub_b0     = borrow_q;
    bus.res_word   = res_word_q;
    bus.res_last   = res_last_q;
    bus.borrow_out = bout_q;
    bus.zero       = zero_q;
  end

  always_comb begin
    opx_d      = opx_q;
    opy_d      = opy_q;
    borrow_d   = borrow_q;
    cnt_d      = cnt_q;
    zacc_d     = zacc_q;
    res_word_d = res_word_q;
    res_last_d = res_last_q;
    bout_d     = bout_q;
    zero_d     = zero_q;
    unique case (1'b1)
      state_q[IDLE]:
        if (bus.start) begin
          borrow_d = bus.borrow_in;
          cnt_d    = '0;
          zacc_d   = 1'b1;
          bout_d   = 1'b0;
          zero_d   = 1'b0;
        end
      state_q[ACCEPT]:
        if (bus.word_valid) begin
          opx_d = bus.a_word;
          opy_d = bus.b_word;
        end
      state_q[EVAL]: begin
        res_word_d = bus.sub_d;
        borrow_d   = bus.sub_b32;
        zacc_d     = zacc_q & (bus.sub_d == '0);
        res_last_d = (cnt_q == LAST);
      end
      state_q[EMIT]:
        if (bus.res_ready && !res_last_q)
          cnt_d = cnt_q + 1'b1;
      state_q[FINISH]: begin
        bout_d = borrow_q;
        zero_d = zacc_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opx_q      <= '0;
      opy_q      <= '0;
      borrow_q   <= 1'b0;
      cnt_q      <= '0;
      zacc_q     <= 1'b0;
      res_word_q <= '0;
      res_last_q <= 1'b0;
      bout_q     <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      opx_q      <= opx_d;
      opy_q      <= opy_d;
      borrow_q   <= borrow_d;
      cnt_q      <= cnt_d;
      zacc_q     <= zacc_d;
      res_word_q <= res_word_d;
      res_last_q <= res_last_d;
      bout_q     <= bout_d;
      zero_q     <= zero_d;
    end
  end

endmodule
